// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO: {last,keep,data} entries, per-packet beat limit with
// truncation, and store-and-forward or cut-through egress gated by rd_en.
module axis_pkt_fifo #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned KEEP_W    = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned LEN_W     = 12,
  parameter bit          STORE_FWD = 1'b1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic [KEEP_W-1:0]        s_keep,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [KEEP_W-1:0]        m_keep,
  input  logic                     rd_en,
  input  logic [LEN_W-1:0]         max_len,
  output logic                     pkt_done,
  output logic                     trunc_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DISCARD} state_t;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_level, r_pkt_cnt;
  state_t            r_state;
  logic [LEN_W-1:0]  r_bc, r_lim;
  logic              r_up, r_pkt_done, r_trunc;

  logic              w_full, w_empty, w_acc, w_wr, w_rd, w_sf_ok;
  logic              w_force, w_wlast;
  logic [LEN_W-1:0]  w_bc_inc;
  logic [ENT_W-1:0]  w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // r_up holds s_ready low until the first clock edge after reset releases.
  assign s_ready = r_up & ((r_state == S_DISCARD) | ~w_full);
  assign w_acc   = s_valid & s_ready;
  assign w_wr    = w_acc & (r_state != S_DISCARD);

  assign w_head  = r_mem[r_rptr];
  assign m_data  = w_head[DATA_W-1:0];
  assign m_keep  = w_head[DATA_W +: KEEP_W];
  assign m_last  = w_head[ENT_W-1];

  // Full releases a store-and-forward FIFO holding a packet longer than DEPTH.
  assign w_sf_ok = STORE_FWD ? ((r_pkt_cnt != '0) | w_full) : 1'b1;
  assign m_valid = rd_en & ~w_empty & w_sf_ok;
  assign w_rd    = m_valid & m_ready;

  always_comb begin
    w_force  = 1'b0;
    w_bc_inc = (r_bc == '1) ? r_bc : r_bc + LEN_W'(1);
    unique case (r_state)
      S_IDLE:   w_force = ~s_last & (max_len == LEN_W'(1));
      S_ACTIVE: w_force = ~s_last & (r_lim != '0) & ((r_bc + LEN_W'(1)) == r_lim);
      default:  w_force = 1'b0;
    endcase
  end

  assign w_wlast = s_last | w_force;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_bc    <= '0;
      r_lim   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_trunc <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          S_IDLE: begin
            r_lim <= max_len;
            r_bc  <= LEN_W'(1);
            if (s_last) begin
              r_state <= S_IDLE;
            end else if (w_force) begin
              r_trunc <= 1'b1;
              r_state <= S_DISCARD;
            end else begin
              r_state <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            r_bc <= w_bc_inc;
            if (s_last) begin
              r_state <= S_IDLE;
            end else if (w_force) begin
              r_trunc <= 1'b1;
              r_state <= S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (s_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_up       <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_pkt_cnt  <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_up       <= 1'b1;
      r_pkt_done <= w_rd & m_last;
      if (w_wr) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_rd) r_rptr <= r_rptr + ADDR_W'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
      unique case ({w_wr & w_wlast, w_rd & m_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + (ADDR_W + 1)'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - (ADDR_W + 1)'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_wlast, s_keep, s_data};
  end

  assign pkt_done  = r_pkt_done;
  assign trunc_err = r_trunc;
  assign level     = r_level;
  assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: a store-and-forward instance driven by directed
// and random packets, plus a cut-through instance for first-beat latency.
module tb_axis_pkt_fifo;

  localparam int DW = 16;
  localparam int KW = 8;
  localparam int DEPTH = 32;
  localparam int LW = 12;
  localparam int AW = 5;
  localparam int EW = DW + KW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst;

  logic [DW-1:0] s_data, m_data;
  logic [KW-1:0] s_keep, m_keep;
  logic          s_valid, s_last, s_ready, m_valid, m_last, m_ready, rd_en;
  logic [LW-1:0] max_len;
  logic          pkt_done, trunc_err;
  logic [AW:0]   level, pkt_cnt;

  logic [DW-1:0] c_s_data, c_m_data;
  logic [KW-1:0] c_s_keep, c_m_keep;
  logic          c_s_valid, c_s_last, c_s_ready, c_m_valid, c_m_last, c_m_ready, c_rd_en;
  logic [LW-1:0] c_max_len;
  logic          c_pkt_done, c_trunc_err;
  logic [AW:0]   c_level, c_pkt_cnt;

  axis_pkt_fifo #(.DATA_W(DW), .KEEP_W(KW), .DEPTH(DEPTH), .LEN_W(LW), .STORE_FWD(1'b1)) u_sf (
    .clk(clk), .arst(arst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .s_keep(s_keep), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .m_keep(m_keep), .rd_en(rd_en),
    .max_len(max_len), .pkt_done(pkt_done), .trunc_err(trunc_err),
    .level(level), .pkt_cnt(pkt_cnt));

  axis_pkt_fifo #(.DATA_W(DW), .KEEP_W(KW), .DEPTH(DEPTH), .LEN_W(LW), .STORE_FWD(1'b0)) u_ct (
    .clk(clk), .arst(arst), .s_data(c_s_data), .s_valid(c_s_valid), .s_last(c_s_last),
    .s_ready(c_s_ready), .s_keep(c_s_keep), .m_data(c_m_data), .m_valid(c_m_valid),
    .m_last(c_m_last), .m_ready(c_m_ready), .m_keep(c_m_keep), .rd_en(c_rd_en),
    .max_len(c_max_len), .pkt_done(c_pkt_done), .trunc_err(c_trunc_err),
    .level(c_level), .pkt_cnt(c_pkt_cnt));

  int n_cmp = 0;
  int n_bad = 0;
  int exp_pkts = 0, exp_trunc = 0, seen_done = 0, seen_trunc = 0;
  logic [EW-1:0] sf_q[$];
  logic [EW-1:0] ct_q[$];
  bit rnd_mr = 1'b0;
  bit rnd_rd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rnd_mr) m_ready = ($urandom_range(0, 3) != 0);
    if (rnd_rd) rd_en = ($urandom_range(0, 7) != 0);
  end

  logic [EW-1:0] prev_ent;
  bit prev_hold = 1'b0;
  always @(negedge clk) begin
    if (arst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && rd_en) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'({m_last, m_keep, m_data}), 64'(prev_ent));
      end
      if (m_valid && m_ready) begin
        if (sf_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sf_unexpected_beat: got %0h expected none", {m_last, m_keep, m_data});
        end else begin
          chk("sf_beat", 64'({m_last, m_keep, m_data}), 64'(sf_q.pop_front()));
        end
      end
      if (pkt_done) seen_done++;
      if (trunc_err) seen_trunc++;
      prev_hold = m_valid && !m_ready;
      prev_ent = {m_last, m_keep, m_data};
    end
  end

  always @(negedge clk) begin
    if (!arst && c_m_valid && c_m_ready) begin
      if (ct_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ct_unexpected_beat: got %0h expected none", {c_m_last, c_m_keep, c_m_data});
      end else begin
        chk("ct_beat", 64'({c_m_last, c_m_keep, c_m_data}), 64'(ct_q.pop_front()));
      end
    end
  end

  // Reference: a packet of len beats with limit ml emerges as its first min(len, ml)
  // beats (ml=0 means no limit), the final one marked last.
  task automatic send_pkt(input int len, input int ml, input bit chk_sfv, input bit chk_rdy, input int gap);
    logic [EW-1:0] beats[$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int eff;
    bit acc;
    int tmo;
    eff = (ml != 0 && len > ml) ? ml : len;
    for (int i = 0; i < len; i++) begin
      d = DW'($urandom);
      k = KW'($urandom);
      beats.push_back({(i == len - 1), k, d});
    end
    for (int i = 0; i < eff; i++) sf_q.push_back({(i == eff - 1), beats[i][EW-2:0]});
    exp_pkts++;
    if (eff < len) exp_trunc++;
    for (int i = 0; i < len; i++) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      {s_last, s_keep, s_data} = beats[i];
      max_len = LW'(ml);
      s_valid = 1'b1;
      tmo = 0;
      do begin
        @(negedge clk);
        acc = s_ready;
        if (chk_rdy) chk("discard_ready", 64'(s_ready), 64'd1);
        if (chk_sfv) chk("sf_wait_valid", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        tmo++;
      end while (!acc && tmo < 1000);
      if (!acc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ingress_timeout: beat %0d never accepted", i);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int t = 0; t < 5000 && (level != 0 || sf_q.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(nm, 64'(level), 64'd0);
  endtask

  bit done4;

  initial begin
    s_valid = 0; s_last = 0; s_data = '0; s_keep = '0; max_len = '0;
    m_ready = 1; rd_en = 1;
    c_s_valid = 0; c_s_last = 0; c_s_data = '0; c_s_keep = '0; c_max_len = '0;
    c_m_ready = 1; c_rd_en = 1;
    arst = 0;
    #2 arst = 1;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_trunc", 64'(trunc_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    arst = 0;
    #1 chk("rel_s_ready_pre", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_s_ready_post", 64'(s_ready), 64'd1);
    chk("rel_ct_s_ready", 64'(c_s_ready), 64'd1);

    // store-and-forward: nothing until the last beat is written
    send_pkt(11, 0, 1'b1, 1'b0, 0);
    chk("t1_valid_after_last", 64'(m_valid), 64'd1);
    wait_drain("t1_drain");
    chk("t1_pkt_done", 64'(seen_done), 64'd1);

    // cut-through latency
    for (int i = 0; i < 11; i++) begin
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      d = DW'($urandom);
      k = KW'($urandom);
      {c_s_last, c_s_keep, c_s_data} = {(i == 10), k, d};
      c_s_valid = 1'b1;
      ct_q.push_back({(i == 10), k, d});
      @(negedge clk);
      chk("ct_s_ready", 64'(c_s_ready), 64'd1);
      if (i == 0) chk("ct_valid_pre", 64'(c_m_valid), 64'd0);
      @(posedge clk); #1;
      if (i == 0) begin
        chk("ct_valid_first", 64'(c_m_valid), 64'd1);
        chk("ct_first_data", 64'(c_m_data), 64'(d));
      end
    end
    c_s_valid = 1'b0;
    c_s_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ct_pkt_cnt_zero", 64'(c_pkt_cnt), 64'd0);
    chk("ct_level_zero", 64'(c_level), 64'd0);
    chk("ct_q_empty", 64'(ct_q.size()), 64'd0);

    // truncation at 4 beats
    send_pkt(10, 4, 1'b0, 1'b1, 0);
    wait_drain("t3_drain");
    chk("t3_trunc_once", 64'(seen_trunc), 64'd1);

    // full / backpressure
    m_ready = 1'b0;
    done4 = 1'b0;
    fork
      begin
        send_pkt(34, 0, 1'b0, 1'b0, 0);
        done4 = 1'b1;
      end
    join_none
    for (int t = 0; t < 200 && level != 6'd32; t++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t4_full_s_ready", 64'(s_ready), 64'd0);
    chk("t4_full_level", 64'(level), 64'd32);
    chk("t4_full_release_valid", 64'(m_valid), 64'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    chk("t4_level_after_read", 64'(level), 64'd31);
    chk("t4_s_ready_reopen", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    chk("t4_level_refill", 64'(level), 64'd32);
    rnd_mr = 1'b1;
    for (int t = 0; t < 2000 && !done4; t++) begin
      @(posedge clk); #1;
    end
    chk("t4_sender_done", 64'(done4), 64'd1);
    rnd_mr = 1'b0;
    #2 m_ready = 1'b1;
    wait_drain("t4_drain");

    // rd_en gating
    rd_en = 1'b0;
    send_pkt(3, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_gated_valid", 64'(m_valid), 64'd0);
    end
    chk("t5_gated_level", 64'(level), 64'd3);
    @(posedge clk); #1 rd_en = 1'b1;
    wait_drain("t5_drain");

    // random packets
    rnd_mr = 1'b1;
    rnd_rd = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len, ml;
      len = $urandom_range(1, 40);
      ml = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      send_pkt(len, ml, 1'b0, 1'b0, 20);
    end
    rnd_mr = 1'b0;
    rnd_rd = 1'b0;
    #2;
    m_ready = 1'b1;
    rd_en = 1'b1;
    wait_drain("rand_drain");
    chk("rand_pkt_cnt_zero", 64'(pkt_cnt), 64'd0);

    // reset mid-packet
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {s_last, s_keep, s_data} = {1'b0, KW'($urandom), DW'($urandom)};
      max_len = '0;
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("t6_level5", 64'(level), 64'd5);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    @(negedge clk) arst = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_pkt(6, 0, 1'b0, 1'b0, 0);
    wait_drain("t6_drain");

    chk("pkt_done_count", 64'(seen_done), 64'(exp_pkts));
    chk("trunc_count", 64'(seen_trunc), 64'(exp_trunc));
    chk("sf_q_empty", 64'(sf_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
